// File: rtl/meas_sched.sv
// -----------------------------------------------------------------------------
// meas_sched -- periodic measurement scheduler.
//
// Generates the gate for an external pulse counter, captures the latched edge
// count after each gate window, and sends it as a 4-byte frame to a UART
// transmitter: header, sequence number, count, XOR checksum.
//
// Ports
//   clk_in       in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   enable       in   high = run periodic gate windows
//   count_in     in   [7:0] latched edge count from the pulse counter
//   tim025       out  gate: 0 = counting window, 1 = latch/clear strobe
//   tx_data      out  [7:0] byte offered to the transmitter
//   tx_valid     out  tx_data valid
//   tx_ready     in   transmitter accepts when tx_valid && tx_ready
//   busy         out  a frame is pending or being sent
//   overrun_cnt  out  [7:0] dropped samples, saturating at 255
// -----------------------------------------------------------------------------
module meas_sched #(
    parameter int         GATE_CYCLES = 12500000,
    parameter logic [7:0] HDR         = 8'hA5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] count_in,
    output logic       tim025,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    localparam logic [23:0] GATE_LAST = 24'(GATE_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_CNT,
        ST_SUM
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [23:0] gate_cnt;
    logic        strobe_p0;
    logic [7:0]  hold;
    logic        pending;
    logic [7:0]  frame;
    logic [7:0]  seq;
    state_t      state_q;
    state_t      state_d;

    logic take;
    logic accept;

    // Gate timer: gate_cnt counts window cycles 1..GATE_CYCLES, 0 marks the
    // idle/strobe cycle. strobe_p0 flags the strobe cycle of a window that ran
    // to completion, so an aborted window never produces a capture.
    always_ff @(posedge clk_in) begin
        if (reset || !enable) begin
            gate_cnt  <= '0;
            tim025    <= 1'b1;
            strobe_p0 <= 1'b0;
        end else if (gate_cnt == GATE_LAST) begin
            gate_cnt  <= '0;
            tim025    <= 1'b1;
            strobe_p0 <= 1'b1;
        end else begin
            gate_cnt  <= gate_cnt + 24'd1;
            tim025    <= 1'b0;
            strobe_p0 <= 1'b0;
        end
    end

    // The FSM empties the holding register in the same cycle it is loaded
    // again, so a capture colliding with that hand-off is not an overrun.
    assign take   = (state_q == ST_IDLE) && pending;
    assign accept = strobe_p0 && (!pending || take);

    // Capture stage: one-deep holding register feeding the frame register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pending     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
            if (strobe_p0 && !accept) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            hold <= count_in;
        end
        if (take) begin
            frame <= hold;
        end
    end

    // Transmit stage: state register and sequence number
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seq     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_SUM && tx_ready) begin
                seq <= seq + 8'd1;
            end
        end
    end

    // Outputs depend only on registered state, so tx_data is stable for as
    // long as a byte waits for tx_ready.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pending) state_d = ST_HDR;
            end
            ST_HDR: begin
                tx_valid = 1'b1;
                tx_data  = HDR;
                if (tx_ready) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq;
                if (tx_ready) state_d = ST_CNT;
            end
            ST_CNT: begin
                tx_valid = 1'b1;
                tx_data  = frame;
                if (tx_ready) state_d = ST_SUM;
            end
            ST_SUM: begin
                tx_valid = 1'b1;
                tx_data  = HDR ^ seq ^ frame;
                if (tx_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = pending || (state_q != ST_IDLE);

endmodule

// File: tb/tb_meas_sched.sv
`timescale 1ns/1ps
module tb_meas_sched;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] count_in;
    logic       tim025;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic [7:0] overrun_cnt;

    int errors = 0;
    int checks = 0;

    meas_sched #(.GATE_CYCLES(10), .HDR(8'hA5)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .count_in    (count_in),
        .tim025      (tim025),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tx_ready = 1'b1; count_in = 8'h00;
        tick(); tick();
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL reset_tim025: got %b want 1", tim025); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun_cnt !== 8'h00) begin errors++; $display("FAIL reset_overrun: got %h want 00", overrun_cnt); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [4];
        exp[0] = 8'hA5; exp[1] = 8'h00; exp[2] = 8'h25; exp[3] = 8'h80;
        count_in = 8'd37; tx_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (tim025 !== 1'b0) begin errors++; $display("FAIL basic_window[%0d]: got %b want 0", i, tim025); end
        end
        tick();
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL basic_strobe: got %b want 1", tim025); end
        tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_s1: got valid=%b busy=%b want 0 1", tx_valid, busy); end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin errors++; $display("FAIL basic_byte[%0d]: got v=%b %h want v=1 %h", i, tx_valid, tx_data, exp[i]); end
        end
        tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_end: got valid=%b busy=%b want 0 0", tx_valid, busy); end
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL basic_gate_off: got %b want 1", tim025); end
    endtask

    task automatic test_backpressure();
        count_in = 8'd37; tx_ready = 1'b1; enable = 1'b1;
        repeat (11) tick();
        tick();
        enable = 1'b0;
        tick();
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL bp_hdr: got %h want a5", tx_data); end
        tick();
        checks++; if (tx_data !== 8'h01) begin errors++; $display("FAIL bp_seq: got %h want 01", tx_data); end
        tick();
        checks++; if (tx_data !== 8'h25) begin errors++; $display("FAIL bp_cnt: got %h want 25", tx_data); end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h25) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 25", i, tx_valid, tx_data); end
        end
        tx_ready = 1'b1;
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin errors++; $display("FAIL bp_sum: got v=%b %h want v=1 81", tx_valid, tx_data); end
        tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_end: got valid=%b busy=%b want 0 0", tx_valid, busy); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_d [9];
        logic       exp_v [9];
        exp_d[0] = 8'h02; exp_d[1] = 8'h11; exp_d[2] = 8'hB6; exp_d[3] = 8'h00; exp_d[4] = 8'hA5;
        exp_d[5] = 8'h03; exp_d[6] = 8'h22; exp_d[7] = 8'h84; exp_d[8] = 8'h00;
        for (int i = 0; i < 9; i++) exp_v[i] = !(i == 3 || i == 8);
        tx_ready = 1'b0; count_in = 8'h11; enable = 1'b1;
        repeat (10) tick();
        tick();
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL ovr_strobe1: got %b want 1", tim025); end
        tick();
        count_in = 8'h22;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy_s1: got %b want 1", busy); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL ovr_stall_a[%0d]: got b=%b v=%b %h want 1 1 a5", i, busy, tx_valid, tx_data); end
        end
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL ovr_strobe2: got %b want 1", tim025); end
        tick();
        count_in = 8'h33;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (busy !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL ovr_stall_b[%0d]: got b=%b %h want 1 a5", i, busy, tx_data); end
        end
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL ovr_strobe3: got %b want 1", tim025); end
        enable = 1'b0;
        tick();
        checks++; if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_count: got %0d want 1", overrun_cnt); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL ovr_stall_c[%0d]: got b=%b v=%b %h want 1 1 a5", i, busy, tx_valid, tx_data); end
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (tx_valid !== exp_v[i] || (exp_v[i] && tx_data !== exp_d[i])) begin
                errors++; $display("FAIL ovr_drain[%0d]: got v=%b %h want v=%b %h", i, tx_valid, tx_data, exp_v[i], exp_d[i]);
            end
        end
        checks++; if (busy !== 1'b0 || overrun_cnt !== 8'd1) begin errors++; $display("FAIL ovr_end: got busy=%b ovr=%0d want 0 1", busy, overrun_cnt); end
    endtask

    task automatic test_abort();
        count_in = 8'h44; tx_ready = 1'b1; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (tim025 !== 1'b0) begin errors++; $display("FAIL abort_window[%0d]: got %b want 0", i, tim025); end
        end
        enable = 1'b0;
        tick();
        checks++; if (tim025 !== 1'b1) begin errors++; $display("FAIL abort_gate: got %b want 1", tim025); end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tim025 !== 1'b1) begin errors++; $display("FAIL abort_idle[%0d]: got v=%b b=%b t=%b want 0 0 1", i, tx_valid, busy, tim025); end
        end
    endtask

    task automatic test_seq_wrap();
        int frames = 0;
        int idx = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        tx_ready = 1'b1; count_in = 8'h5A; enable = 1'b1;
        for (int c = 0; c < 257 * 11 + 40; c++) begin
            tick();
            if (tx_valid === 1'b1) begin
                if (idx == 1) begin
                    checks++; if (tx_data !== 8'(frames)) begin errors++; $display("FAIL wrap_seq[%0d]: got %h want %h", frames, tx_data, 8'(frames)); end
                end
                if (idx == 3) frames++;
                idx = (idx + 1) % 4;
            end
            if (frames == 257) break;
        end
        checks++; if (frames != 257) begin errors++; $display("FAIL wrap_timeout: got %0d frames want 257", frames); end
        enable = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_overrun_sat();
        int k = 0;
        bit chk = 0;
        int exp;
        tx_ready = 1'b0; enable = 1'b1;
        for (int c = 0; c < 303 * 11 + 50; c++) begin
            tick();
            if (chk) begin
                exp = (k < 2) ? 0 : ((k - 2 > 255) ? 255 : k - 2);
                checks++; if (overrun_cnt !== 8'(exp)) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, overrun_cnt, exp); end
                chk = 0;
                if (k == 303) break;
            end
            if (tim025 === 1'b1) begin
                k++;
                chk = 1;
            end
        end
        checks++; if (overrun_cnt !== 8'd255 || k != 303) begin errors++; $display("FAIL sat_final: got ovr=%0d strobes=%0d want 255 303", overrun_cnt, k); end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        reset = 1'b1; tick(); reset = 1'b0;
        tx_ready = 1'b1; count_in = 8'h66;
        enable = 1'b1; repeat (11) tick(); tick(); enable = 1'b0;
        repeat (5) tick();
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_first_frame: got v=%b b=%b want 0 0", tx_valid, busy); end
        enable = 1'b1; repeat (11) tick(); tick(); enable = 1'b0;
        tick();
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL rst_hdr: got %h want a5", tx_data); end
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL rst_seq_before: got v=%b %h want 1 01", tx_valid, tx_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || tim025 !== 1'b1 || overrun_cnt !== 8'd0) begin
            errors++; $display("FAIL rst_abort: got v=%b b=%b t=%b ovr=%0d want 0 0 1 0", tx_valid, busy, tim025, overrun_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet[%0d]: got %b want 0", i, tx_valid); end
        end
        enable = 1'b1; repeat (11) tick(); tick(); enable = 1'b0;
        tick();
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL rst_next_hdr: got %h want a5", tx_data); end
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_next_seq: got v=%b %h want 1 00", tx_valid, tx_data); end
        repeat (4) tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overrun();
        test_abort();
        test_seq_wrap();
        test_overrun_sat();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/meas_sched.md
MEAS_SCHED -- requirements
Module: meas_sched

Interface
REQ-001 Parameter GATE_CYCLES, default 12500000: gate-window length in clk_in cycles; legal range 2 to 2^24-1.
REQ-002 Parameter HDR, default 8'hA5: frame header byte.
REQ-003 clk_in  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  high = run periodic measurements.
REQ-006 count_in  in  8  latched edge count from the pulse counter.
REQ-007 tim025  out  1  gate to the pulse counter; 0 = counting window, 1 = latch/clear strobe.
REQ-008 tx_data  out  8  byte offered to the UART transmitter.
REQ-009 tx_valid  out  1  tx_data valid.
REQ-010 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-011 busy  out  1  high while a frame is pending or being sent.
REQ-012 overrun_cnt  out  8  count of dropped samples; saturates at 255.

Function
REQ-013 Gate timer: with enable low, timer SHALL be cleared and tim025 SHALL be held at 1.
REQ-014 If enable is high in cycle N and the timer is idle, tim025 SHALL be 0 for cycles N+1 .. N+GATE_CYCLES, then 1 for exactly one cycle (strobe cycle S); the pattern SHALL repeat with period GATE_CYCLES+1 while enable stays high.
REQ-015 If enable falls mid-window, tim025 SHALL return to 1 on the next cycle, no strobe SHALL be counted as a measurement, and no capture SHALL occur.
REQ-016 Capture: in cycle S+1 count_in SHALL be sampled into a one-deep holding register and the pending flag SHALL be set.
REQ-017 If pending is already set at capture, the new sample SHALL be dropped, the holding register SHALL be left unchanged, and overrun_cnt SHALL increment, saturating at 255.
REQ-018 TX FSM states: IDLE, HDR, SEQ, CNT, SUM.
REQ-019 IDLE with pending set: on the next cycle, enter HDR, copy the holding register into the frame register, and clear pending; a capture in that same cycle SHALL be accepted, not counted as an overrun.
REQ-020 HDR/SEQ/CNT/SUM SHALL drive tx_valid=1 with tx_data = HDR, seq, frame count, and HDR^seq^count respectively.
REQ-021 Each state SHALL advance to the next only on the cycle that the tx_valid and tx_ready handshake completes; SUM SHALL then go to IDLE.
REQ-022 tx_data SHALL stay stable while tx_valid is high and not yet accepted; tx_valid SHALL be 0 in IDLE.
REQ-023 seq (8 bit) SHALL increment when SUM is accepted and wrap 255 to 0; the first frame after reset SHALL carry seq=0.
REQ-024 An in-flight frame and any pending sample SHALL still be sent after enable falls.
REQ-025 busy SHALL equal pending OR (state != IDLE).
REQ-026 Header tx_valid SHALL first rise in cycle S+2 when the FSM is idle at capture.

Reset
REQ-027 On reset high at a clock edge: tim025=1, tx_valid=0, tx_data=0, busy=0, overrun_cnt=0, seq=0, pending=0, timer=0, FSM=IDLE.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further bytes sent; reset SHALL take priority over every other event in the same cycle.

Verification (GATE_CYCLES=10)
REQ-029 Raise enable with tx_ready=1 and count_in=8'd37 -> tim025 low for 10 cycles, high for 1; frame bytes A5, 00, 25, 80 on consecutive cycles starting at S+2.
REQ-030 Hold tx_ready=0 for 5 cycles during CNT -> tx_valid stays high and tx_data stays 8'h25; the frame completes after tx_ready rises.
REQ-031 Hold tx_ready=0 for 30 cycles -> first capture sent, second held, third dropped; overrun_cnt=1, busy high throughout.
REQ-032 Drop enable at the 4th window cycle -> tim025=1 the next cycle, no capture, no frame.
REQ-033 Run 256 frames -> seq values 0..255 then 0; overrun_cnt held at 255 under 300 forced overruns.
REQ-034 Assert reset during SEQ -> next cycle tx_valid=0, busy=0, and the following frame carries seq=0.
